yutorina_gpr_writer: RTL and testbench
======================================

// Module: yutorina_gpr_writer
// PURPOSE
// - Write-back side of the GPR file: merges single-cycle ALU results and multi-cycle
//   long-op results (load, mul/div) into the single GPR write port.
// - Queues long-op results and keeps a per-register busy scoreboard so decode can stall on pending writes.
// - Sits between the execute/memory stages and yutorina_gpr.
// PARAMETERS
// - DATA_WIDTH   32  width of a GPR word
// - ADDR_WIDTH    5  GPR address width
// - REG_NUM      32  number of GPRs; must equal 2**ADDR_WIDTH
// - QUEUE_DEPTH   4  long-op result queue entries; power of two, >= 2
// PORTS
// - clock          in   1           clock
// - reset          in   1           reset, synchronous, active-high
// - flush          in   1           pipeline flush, synchronous, active-high
// - alu_valid      in   1           ALU result valid this cycle
// - alu_address    in   ADDR_WIDTH  ALU destination register
// - alu_data       in   DATA_WIDTH  ALU result
// - issue_valid    in   1           decode issues a long op; marks issue_address busy
// - issue_address  in   ADDR_WIDTH  long-op destination register
// - long_valid     in   1           long-op result offered
// - long_ready     out  1           queue accepts a result (= queue not full)
// - long_address   in   ADDR_WIDTH  long-op destination register
// - long_data      in   DATA_WIDTH  long-op result
// - query_address0 in   ADDR_WIDTH  scoreboard query, source operand 0
// - busy0          out  1           query_address0 has a pending long-op write
// - query_address1 in   ADDR_WIDTH  scoreboard query, source operand 1
// - busy1          out  1           query_address1 has a pending long-op write
// - queue_count    out  $clog2(QUEUE_DEPTH+1)  entries held in the queue
// - write_enable_  out  1           GPR write enable, active-low, registered
// - write_address  out  ADDR_WIDTH  GPR write address, registered
// - write_data     out  DATA_WIDTH  GPR write data, registered
// BEHAVIOUR
// - Reset: write_enable_=1 (disabled), write_address=0, write_data=0, queue empty,
//   queue_count=0, all busy bits 0, long_ready=1. Reset overrides flush and all inputs.
// - Output stage: registered. At most one GPR write per cycle.
// - Priority each cycle: ALU result first, then the queue head.
//   - ALU: alu_valid at edge N drives write_enable_=0 with that address/data during cycle N+1.
//     Latency is 1 cycle.
//   - Queue head dequeues only when alu_valid=0. Same 1-cycle latency from the dequeue edge.
//   - Otherwise write_enable_ returns to 1. Address and data hold their last value.
// - $0 is never written:
//   - An ALU or queue-head result addressed to 0 is consumed, but write_enable_ stays 1.
//   - issue_address=0 never sets a busy bit.
// - Queue:
//   - In-order FIFO. Enqueue when long_valid && long_ready.
//   - long_ready = (count != QUEUE_DEPTH), taken from the registered count. When full,
//     no enqueue occurs even if a dequeue happens in the same cycle.
//   - Pointers wrap modulo QUEUE_DEPTH. Enqueue and dequeue in the same cycle leave the count unchanged.
// - Scoreboard (REG_NUM bits):
//   - Set on issue_valid.
//   - Cleared on the edge that loads the output stage with a queue-head write to that register.
//     The register therefore reads not-busy in the cycle write_enable_ is asserted; GPR read-port bypass covers it.
//   - Set and clear of the same register in the same cycle: set wins.
//   - busy0/busy1 are combinational lookups. Query address 0 always returns 0.
//   - Decode must not issue a long op to a register that is already busy. The bench asserts this.
// - Flush:
//   - Empties the queue and clears all busy bits. long_valid and issue_valid in the flush cycle are discarded.
//   - A write already in the output stage still completes. alu_valid in the flush cycle is still written (older instruction).
// STRUCTURE
// - Shared headers (isa.h / global_config.h): YUTORINA_ENABLE_/DISABLE_, word and register-address
//   widths, REGISTER_NUM, zero-register address, reset level.
// - Sub-module yutorina_writeback_fifo: parameterised FIFO (push/pop/full/empty/count).
// - Top level holds the arbiter, scoreboard and output register.
// TESTING
// - Reset held 2 cycles -> write_enable_=1, queue_count=0, busy0=busy1=0, long_ready=1.
// - alu_valid addr 5 data 32'h0000_1234 at edge N -> cycle N+1: write_enable_=0, addr 5,
//   data 32'h1234; cycle N+2: write_enable_=1.
// - issue r7, long result r7=32'hDEAD_BEEF queued while alu_valid (r3) held 3 cycles ->
//   busy on r7 stays 1. ALU writes r3 ×3, then r7 is written in the first cycle after alu_valid drops.
//   Busy on r7 reads 0 in that cycle.
// - alu_valid held; 5 long results r1..r5 offered -> 4 accepted, queue_count=4, long_ready=0,
//   r5 stalled. Release alu -> writes r1, r2, r3, r4, r5 in order on consecutive cycles.
// - alu_valid addr 0 data 32'hFFFF_FFFF and issue addr 0 -> no write_enable_=0 pulse; busy on query 0 reads 0.
// - 2 results queued, r8/r9 busy, flush -> next cycle queue_count=0, busy all 0, and no queued write is emitted.

Source files
------------

// File: rtl/yutorina_gpr_writer_pkg.sv
// Shared constants for the GPR write-back slice.
// - YUTORINA_ENABLE_/YUTORINA_DISABLE_: levels of the active-low enable strobes.
// - WORD_WIDTH, REG_ADDR_WIDTH, REGISTER_NUM: default GPR geometry.
// - ZERO_REG: address of the hard-wired zero register.
// - RESET_LEVEL: asserted level of the synchronous reset.
// - wb_entry_t: one queued long-op result (destination + data) at default geometry.
package yutorina_gpr_writer_pkg;

  localparam logic        YUTORINA_ENABLE_  = 1'b0;
  localparam logic        YUTORINA_DISABLE_ = 1'b1;
  localparam int unsigned WORD_WIDTH        = 32;
  localparam int unsigned REG_ADDR_WIDTH    = 5;
  localparam int unsigned REGISTER_NUM      = 32;
  localparam int unsigned ZERO_REG          = 0;
  localparam logic        RESET_LEVEL       = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/yutorina_writeback_fifo.sv
// In-order result queue for multi-cycle long-op write-backs.
// Ports:
// - clock, reset (sync, active-high), flush (sync, empties the queue)
// - push/din: enqueue, ignored while full (even if a pop happens the same cycle)
// - pop/dout: dequeue, ignored while empty; dout shows the current head
// - full, empty, count: occupancy derived from the registered count
module yutorina_writeback_fifo
  import yutorina_gpr_writer_pkg::*;
#(
  parameter int unsigned WIDTH = REG_ADDR_WIDTH + WORD_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset == RESET_LEVEL || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      count_q <= count_q + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/yutorina_gpr_writer.sv
// Write-back arbiter for the single GPR write port.
// Ports:
// - clock, reset (sync, active-high), flush (sync, drops queued results and busy bits)
// - alu_valid/alu_address/alu_data: single-cycle result, highest priority
// - issue_valid/issue_address: marks a long-op destination busy
// - long_valid/long_ready/long_address/long_data: long-op result handshake into the queue
// - query_address0/1 -> busy0/1: combinational scoreboard lookups
// - queue_count: queued long-op results
// - write_enable_ (active-low), write_address, write_data: registered GPR write port
module yutorina_gpr_writer
  import yutorina_gpr_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH  = REG_ADDR_WIDTH,
  parameter int unsigned REG_NUM     = REGISTER_NUM,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               alu_valid,
  input  logic [ADDR_WIDTH-1:0]              alu_address,
  input  logic [DATA_WIDTH-1:0]              alu_data,
  input  logic                               issue_valid,
  input  logic [ADDR_WIDTH-1:0]              issue_address,
  input  logic                               long_valid,
  output logic                               long_ready,
  input  logic [ADDR_WIDTH-1:0]              long_address,
  input  logic [DATA_WIDTH-1:0]              long_data,
  input  logic [ADDR_WIDTH-1:0]              query_address0,
  output logic                               busy0,
  input  logic [ADDR_WIDTH-1:0]              query_address1,
  output logic                               busy1,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               write_enable_,
  output logic [ADDR_WIDTH-1:0]              write_address,
  output logic [DATA_WIDTH-1:0]              write_data
);

  localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_WIDTH-1:0] fifo_din;
  logic [ENTRY_WIDTH-1:0] fifo_dout;
  logic [ADDR_WIDTH-1:0]  head_address;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [REG_NUM-1:0]     busy;
  logic [REG_NUM-1:0]     set_mask;
  logic [REG_NUM-1:0]     clear_mask;

  assign long_ready = !fifo_full;
  assign fifo_push  = long_valid && !fifo_full && !flush;
  // The head only drains in ALU-idle cycles; a flush discards it instead.
  assign fifo_pop   = !alu_valid && !fifo_empty && !flush;
  assign fifo_din   = {long_address, long_data};
  assign {head_address, head_data} = fifo_dout;

  yutorina_writeback_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (fifo_pop && head_address != ZERO_ADDR) clear_mask[head_address] = 1'b1;
    if (issue_valid && issue_address != ZERO_ADDR) set_mask[issue_address] = 1'b1;
  end

  // Clear is applied before set so a same-cycle re-issue keeps the bit.
  always_ff @(posedge clock) begin
    if (reset == RESET_LEVEL || flush) busy <= '0;
    else                               busy <= (busy & ~clear_mask) | set_mask;
  end

  assign busy0 = (query_address0 != ZERO_ADDR) && busy[query_address0];
  assign busy1 = (query_address1 != ZERO_ADDR) && busy[query_address1];

  // Results aimed at the zero register are consumed without a write strobe
  // and leave the address/data registers untouched.
  always_ff @(posedge clock) begin
    if (reset == RESET_LEVEL) begin
      write_enable_ <= YUTORINA_DISABLE_;
      write_address <= '0;
      write_data    <= '0;
    end else if (alu_valid) begin
      if (alu_address != ZERO_ADDR) begin
        write_enable_ <= YUTORINA_ENABLE_;
        write_address <= alu_address;
        write_data    <= alu_data;
      end else begin
        write_enable_ <= YUTORINA_DISABLE_;
      end
    end else if (fifo_pop) begin
      if (head_address != ZERO_ADDR) begin
        write_enable_ <= YUTORINA_ENABLE_;
        write_address <= head_address;
        write_data    <= head_data;
      end else begin
        write_enable_ <= YUTORINA_DISABLE_;
      end
    end else begin
      write_enable_ <= YUTORINA_DISABLE_;
    end
  end

endmodule

// File: tb/tb_yutorina_gpr_writer.sv
// Self-checking bench for yutorina_gpr_writer: a directed vector table, hand-written
// multi-cycle sequences and a randomized phase, all compared against a queue-based
// reference model of the write-back rules.
module tb_yutorina_gpr_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned QD = 4;
  localparam int unsigned CW = $clog2(QD + 1);

  logic          clock = 1'b0;
  logic          reset, flush;
  logic          alu_valid, issue_valid, long_valid;
  logic [AW-1:0] alu_address, issue_address, long_address;
  logic [DW-1:0] alu_data, long_data;
  logic [AW-1:0] query_address0, query_address1;
  logic          long_ready, busy0, busy1, write_enable_;
  logic [CW-1:0] queue_count;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;

  yutorina_gpr_writer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .REG_NUM     (32),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .alu_valid      (alu_valid),
    .alu_address    (alu_address),
    .alu_data       (alu_data),
    .issue_valid    (issue_valid),
    .issue_address  (issue_address),
    .long_valid     (long_valid),
    .long_ready     (long_ready),
    .long_address   (long_address),
    .long_data      (long_data),
    .query_address0 (query_address0),
    .busy0          (busy0),
    .query_address1 (query_address1),
    .busy1          (busy1),
    .queue_count    (queue_count),
    .write_enable_  (write_enable_),
    .write_address  (write_address),
    .write_data     (write_data)
  );

  always #5 clock = ~clock;

  // Reference model state.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;
  entry_t        m_q[$];
  logic [31:0]   m_busy;
  logic          m_en_;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_address = '0; alu_data = '0;
    issue_valid = 1'b0; issue_address = '0;
    long_valid = 1'b0; long_address = '0; long_data = '0;
  endtask

  // Apply the write-back rules for one clock edge to the model.
  task automatic model_edge();
    entry_t h;
    bit     ready;
    if (reset) begin
      m_q.delete(); m_busy = '0; m_en_ = 1'b1; m_addr = '0; m_data = '0;
      return;
    end
    ready = (m_q.size() != QD);
    if (alu_valid) begin
      m_en_ = (alu_address == 0);
      if (alu_address != 0) begin m_addr = alu_address; m_data = alu_data; end
    end else if (m_q.size() != 0 && !flush) begin
      h = m_q.pop_front();
      m_en_ = (h.a == 0);
      if (h.a != 0) begin m_addr = h.a; m_data = h.d; m_busy[h.a] = 1'b0; end
    end else begin
      m_en_ = 1'b1;
    end
    if (flush) begin
      m_q.delete(); m_busy = '0;
    end else begin
      if (long_valid && ready) m_q.push_back('{a: long_address, d: long_data});
      if (issue_valid && issue_address != 0) m_busy[issue_address] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("write_enable_", 64'(write_enable_), 64'(m_en_));
    if (m_en_ == 1'b0) begin
      check("write_address", 64'(write_address), 64'(m_addr));
      check("write_data", 64'(write_data), 64'(m_data));
    end
    check("queue_count", 64'(queue_count), 64'(m_q.size()));
    check("long_ready", 64'(long_ready), 64'(m_q.size() != QD));
    check("busy0", 64'(busy0), 64'(query_address0 != 0 && m_busy[query_address0]));
    check("busy1", 64'(busy1), 64'(query_address1 != 0 && m_busy[query_address1]));
  endtask

  task automatic step();
    if (!reset && issue_valid && issue_address != 0 && m_busy[issue_address]) begin
      errors++;
      $display("FAIL issue_to_busy: register %0d already busy", issue_address);
    end
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          exp_en_;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  32'h0000_1234};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd5,  32'h0000_1234};
    vecs[3] = '{1'b1, 5'd31, 32'hA5A5_5A5A, 1'b0, 5'd31, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b0, 5'd1,  32'h0000_0001};

    idle();
    query_address0 = 5'd0; query_address1 = 5'd7;
    m_en_ = 1'b1; m_addr = '0; m_data = '0; m_busy = '0;

    // Reset for two cycles.
    reset = 1'b1;
    step(); step();
    check("reset_we", 64'(write_enable_), 64'(1));
    check("reset_count", 64'(queue_count), 64'(0));
    check("reset_ready", 64'(long_ready), 64'(1));
    check("reset_busy", 64'({busy0, busy1}), 64'(0));
    idle();

    // Table of single ALU writes; addr 0 row also issues to $0.
    for (int i = 0; i < 5; i++) begin
      alu_valid = vecs[i].av; alu_address = vecs[i].aa; alu_data = vecs[i].ad;
      issue_valid = (vecs[i].av && vecs[i].aa == 0); issue_address = '0;
      step();
      check("vec_we", 64'(write_enable_), 64'(vecs[i].exp_en_));
      if (vecs[i].exp_en_ == 1'b0) begin
        check("vec_addr", 64'(write_address), 64'(vecs[i].exp_a));
        check("vec_data", 64'(write_data), 64'(vecs[i].exp_d));
      end
      check("vec_busy_q0", 64'(busy0), 64'(0));
    end
    idle(); step();
    check("alu_release_we", 64'(write_enable_), 64'(1));

    // Long op r7 waits behind three ALU writes to r3.
    query_address0 = 5'd7;
    alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'h3;
    issue_valid = 1'b1; issue_address = 5'd7;
    step();
    issue_valid = 1'b0;
    long_valid = 1'b1; long_address = 5'd7; long_data = 32'hDEAD_BEEF;
    step();
    long_valid = 1'b0;
    step();
    check("r7_busy_held", 64'(busy0), 64'(1));
    check("r3_write", 64'(write_address), 64'(3));
    alu_valid = 1'b0;
    step();
    check("r7_we", 64'(write_enable_), 64'(0));
    check("r7_addr", 64'(write_address), 64'(7));
    check("r7_data", 64'(write_data), 64'(32'hDEAD_BEEF));
    check("r7_busy_clear", 64'(busy0), 64'(0));
    step();
    check("r7_done_we", 64'(write_enable_), 64'(1));

    // Fill the queue behind a held ALU; fifth result must stall.
    alu_valid = 1'b1; alu_address = 5'd10; alu_data = 32'hA;
    for (int k = 1; k <= 5; k++) begin
      long_valid = 1'b1; long_address = AW'(k); long_data = 32'h100 + DW'(k);
      step();
    end
    check("full_count", 64'(queue_count), 64'(4));
    check("full_ready", 64'(long_ready), 64'(0));
    alu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      long_valid = (k <= 2);
      step();
      check("drain_we", 64'(write_enable_), 64'(0));
      check("drain_addr", 64'(write_address), 64'(k));
      check("drain_data", 64'(write_data), 64'(32'h100 + k));
    end
    idle(); step();

    // Flush with two queued results and r8/r9 busy.
    query_address0 = 5'd8; query_address1 = 5'd9;
    alu_valid = 1'b1; alu_address = 5'd12; alu_data = 32'hC;
    issue_valid = 1'b1; issue_address = 5'd8;
    long_valid = 1'b1; long_address = 5'd8; long_data = 32'h88;
    step();
    issue_address = 5'd9; long_address = 5'd9; long_data = 32'h99;
    step();
    check("pre_flush_count", 64'(queue_count), 64'(2));
    check("pre_flush_busy", 64'({busy0, busy1}), 64'(3));
    idle(); flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", 64'(queue_count), 64'(0));
    check("flush_busy", 64'({busy0, busy1}), 64'(0));
    check("flush_we", 64'(write_enable_), 64'(1));
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_flush_we", 64'(write_enable_), 64'(1));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] ia;
      reset = ($urandom_range(199, 0) == 0);
      flush = ($urandom_range(29, 0) == 0);
      alu_valid = ($urandom_range(9, 0) < 4);
      alu_address = AW'($urandom_range(31, 0));
      alu_data = $urandom;
      ia = AW'($urandom_range(31, 0));
      issue_valid = ($urandom_range(9, 0) < 3) && !m_busy[ia];
      issue_address = ia;
      long_valid = ($urandom_range(1, 0) == 1);
      long_address = AW'($urandom_range(31, 0));
      long_data = $urandom;
      query_address0 = AW'($urandom_range(31, 0));
      query_address1 = ($urandom_range(1, 0) == 1) ? ia : AW'($urandom_range(31, 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
